framebuffer_writer: RTL



---
 rtl/framebuffer_writer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/framebuffer_writer.sv
// framebuffer_writer: buffers 4-bit gray pixels from the pixel engine and
// pushes them into the framebuffer write lane with a 4-phase
// strobe/acknowledge handshake. Each frame starts with a write-pointer reset.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   IDLE       | no frame in progress, strobes low, waiting for start_in
//   PTR_RESET  | fb_reset_ptr_out held high for RESET_CYCLES cycles
//   WAIT_PIXEL | waiting for a buffered pixel, loads it into fb_data_out
//   SETUP      | data stable one cycle before the strobe rises
//   STROBE     | fb_write_out high, held for HOLD_CYCLES and until ack
//   RELEASE    | fb_write_out low, waiting for the ack to drop
module framebuffer_writer #(
    parameter int FRAME_PIXELS = 153600,
    parameter int FIFO_DEPTH   = 4,
    parameter int HOLD_CYCLES  = 2,
    parameter int RESET_CYCLES = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_in,
    input  logic                              pixel_valid_in,
    input  logic [3:0]                        pixel_data_in,
    output logic                              pixel_ready_out,
    output logic [3:0]                        fb_data_out,
    output logic                              fb_write_out,
    output logic                              fb_reset_ptr_out,
    input  logic                              fb_wrote_in,
    output logic                              busy_out,
    output logic                              frame_done_out,
    output logic [$clog2(FRAME_PIXELS+1)-1:0] written_out
);

    localparam int CW = $clog2(FRAME_PIXELS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(RESET_CYCLES + 1);

    localparam logic [CW-1:0] FRAME_MAX  = CW'(FRAME_PIXELS);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_PIXELS - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] RESET_LOAD = RW'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PTR_RESET,
        WAIT_PIXEL,
        SETUP,
        STROBE,
        RELEASE
    } state_t;

    state_t          state;
    logic [HW-1:0]   hold_cnt;
    logic [RW-1:0]   rst_cnt;

    logic [3:0]      fifo_mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [CW-1:0]   accepted;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;
    logic            flush;
    logic [3:0]      fifo_head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

    // Ready depends on registers only, so a full FIFO never takes a push even
    // when a pop happens in the same cycle.
    assign pixel_ready_out = (state != IDLE) && (state != PTR_RESET) &&
                             !fifo_full && (accepted < FRAME_MAX);

    assign push  = pixel_valid_in && pixel_ready_out;
    assign pop   = (state == WAIT_PIXEL) && !fifo_empty;
    assign flush = (state == IDLE) && start_in;

    // Pixel storage; contents are don't-care until a push fills an entry.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= pixel_data_in;
        end
    end

    // FIFO pointers and the accepted-pixel count, cleared at frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            accepted <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            accepted <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                accepted <= accepted + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Frame sequencer with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            hold_cnt         <= '0;
            rst_cnt          <= '0;
            fb_data_out      <= '0;
            fb_write_out     <= 1'b0;
            fb_reset_ptr_out <= 1'b0;
            busy_out         <= 1'b0;
            frame_done_out   <= 1'b0;
            written_out      <= '0;
        end else begin
            frame_done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        state            <= PTR_RESET;
                        rst_cnt          <= RESET_LOAD;
                        fb_reset_ptr_out <= 1'b1;
                        busy_out         <= 1'b1;
                        written_out      <= '0;
                    end
                end
                PTR_RESET: begin
                    if (rst_cnt == '0) begin
                        fb_reset_ptr_out <= 1'b0;
                        state            <= WAIT_PIXEL;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                WAIT_PIXEL: begin
                    if (!fifo_empty) begin
                        fb_data_out <= fifo_head;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    fb_write_out <= 1'b1;
                    hold_cnt     <= HOLD_LOAD;
                    state        <= STROBE;
                end
                STROBE: begin
                    // The strobe must satisfy both the minimum hold and the ack.
                    if (hold_cnt == '0) begin
                        if (fb_wrote_in) begin
                            fb_write_out <= 1'b0;
                            state        <= RELEASE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    if (!fb_wrote_in) begin
                        written_out <= written_out + 1'b1;
                        if (written_out == FRAME_LAST) begin
                            frame_done_out <= 1'b1;
                            busy_out       <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            state <= WAIT_PIXEL;
                        end
                    end
                end
                default: begin
                    state            <= IDLE;
                    fb_write_out     <= 1'b0;
                    fb_reset_ptr_out <= 1'b0;
                    busy_out         <= 1'b0;
                end
            endcase
        end
    end

endmodule
